// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants and state encoding for the instruction fetch unit
package instr_fetch_unit_pkg;

  // Encoding of the EBREAK instruction; fetching it stops the fetch stream.
  localparam logic [31:0] EBREAK_WORD = 32'h00100073;

  // Every instruction occupies one 32-bit word.
  localparam int INSTR_BYTES = 4;

  // RUN fetches, HALT waits for a redirect, FAULT waits for reset.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_out_reg.sv
// rtl/instr_fetch_unit_fetch_out_reg.sv - IF/ID pipeline register with valid/ready hold and flush
module fetch_out_reg #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_load,
  input  logic                 i_ready,
  input  logic [BITS_DATA-1:0] i_instr,
  input  logic [BITS_ADDR-1:0] i_pc,
  output logic                 o_valid,
  output logic [BITS_DATA-1:0] o_instr,
  output logic [BITS_ADDR-1:0] o_pc
);

  logic                 r_valid;
  logic [BITS_DATA-1:0] r_instr;
  logic [BITS_ADDR-1:0] r_pc;

  // Valid flag: flush beats load, load beats a plain handshake drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload only changes on a load, so it stays stable through a stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load && !i_flush) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and requester for a combinational instruction memory
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                   BITS_DATA = 32,
  parameter int                   BITS_ADDR = 7,
  parameter logic [BITS_ADDR-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [BITS_ADDR-1:0] imem_addr,
  input  logic [BITS_DATA-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [BITS_ADDR-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS_DATA-1:0] out_instr,
  output logic [BITS_ADDR-1:0] out_pc,
  output logic                 halted,
  output logic                 fault,
  output logic [31:0]          fetch_count
);

  fetch_state_e         r_state;
  fetch_state_e         w_state_next;
  logic [BITS_ADDR-1:0] r_pc;
  logic [31:0]          r_fetch_count;

  logic w_out_valid;
  logic w_slot_free;
  logic w_fire;
  logic w_misaligned;
  logic w_redirect_ok;
  logic w_flush;
  logic w_fetch;
  logic w_is_ebreak;

  // A misaligned target always faults; an aligned one is honoured unless already faulted.
  assign w_slot_free   = !w_out_valid || out_ready;
  assign w_fire        = w_out_valid && out_ready;
  assign w_misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redirect_ok = redirect_valid && !w_misaligned && (r_state != ST_FAULT);
  assign w_flush       = w_misaligned || w_redirect_ok;
  assign w_fetch       = (r_state == ST_RUN) && w_slot_free && !redirect_valid;
  assign w_is_ebreak   = (imem_rdata == EBREAK_WORD);

  assign imem_addr = r_pc;

  // PC follows an accepted redirect, otherwise advances one word per fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_redirect_ok) begin
      r_pc <= redirect_pc;
    end else if (w_fetch) begin
      r_pc <= r_pc + BITS_ADDR'(INSTR_BYTES);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: fault is terminal, a good redirect resumes, EBREAK stops fetching.
  always_comb begin
    w_state_next = r_state;
    if (w_misaligned) begin
      w_state_next = ST_FAULT;
    end else if (w_redirect_ok) begin
      w_state_next = ST_RUN;
    end else if (w_fetch && w_is_ebreak) begin
      w_state_next = ST_HALT;
    end
  end

  // FSM outputs: fault is sticky because FAULT is left only through reset.
  always_comb begin
    halted = (r_state != ST_RUN);
    fault  = (r_state == ST_FAULT);
  end

  // Count every handshake, including one that coincides with a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_fire) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;

  fetch_out_reg #(
    .BITS_DATA(BITS_DATA),
    .BITS_ADDR(BITS_ADDR)
  ) u_out_reg (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (w_flush),
    .i_load  (w_fetch),
    .i_ready (out_ready),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_out_valid),
    .o_instr (out_instr),
    .o_pc    (out_pc)
  );

  assign out_valid = w_out_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [6:0]  redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [6:0]  out_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [32];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference state: pc, pending instruction, run/halt/fault and handshake count.
  logic [6:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [6:0]  m_opc;
  int          m_state;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[6:2]];

  instr_fetch_unit #(
    .BITS_DATA(32),
    .BITS_ADDR(7),
    .RESET_PC (7'h00)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted),
    .fault         (fault),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 7'h00;
    m_valid = 1'b0;
    m_instr = '0;
    m_opc   = '0;
    m_state = 0;
    m_count = '0;
  endtask

  // One rising edge of the specified behaviour, applied in priority order.
  task automatic model_step(input logic rv, input logic [6:0] rpc, input logic rdy);
    logic fire;
    logic fetch;
    fire  = m_valid && rdy;
    fetch = (m_state == 0) && (!m_valid || rdy) && !rv;
    if (fire) m_count = m_count + 1;
    if (rv && rpc[1:0] != 2'b00) begin
      m_state = 2;
      m_valid = 1'b0;
    end else if (rv && m_state != 2) begin
      m_pc    = rpc;
      m_valid = 1'b0;
      m_state = 0;
    end else if (fetch) begin
      m_instr = mem[m_pc / 4];
      m_opc   = m_pc;
      m_valid = 1'b1;
      m_pc    = 7'((m_pc + 4) % 128);
      if (m_instr == EBREAK) m_state = 1;
    end else if (fire) begin
      m_valid = 1'b0;
    end
  endtask

  // Inputs are applied away from the edge; the model advances alongside the DUT.
  task automatic cycle(input logic rv, input logic [6:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_step(rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_addr", {25'b0, imem_addr}, 32'h00);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // Compare every output against the model once per cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("imem_addr", {25'b0, imem_addr}, {25'b0, m_pc});
      chk("halted", {31'b0, halted}, {31'b0, m_state != 0});
      chk("fault", {31'b0, fault}, {31'b0, m_state == 2});
      chk("fetch_count", fetch_count, m_count);
      if (m_valid) begin
        chk("out_instr", out_instr, m_instr);
        chk("out_pc", {25'b0, out_pc}, {25'b0, m_opc});
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [6:0]  rpc;
    int          fault_cycles;

    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      if (w == EBREAK) w = w ^ 32'd1;
      mem[i] = w;
    end
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    mem[2] = 32'h002081B3;
    mem[3] = EBREAK;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_addr", {25'b0, imem_addr}, 32'h00);
    chk("reset_instr", out_instr, 32'd0);
    chk("reset_count", fetch_count, 32'd0);
    chk("reset_halted", {31'b0, halted}, 32'd0);
    model_reset();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Back-to-back fetch and stall.
    cycle(1'b0, 7'h00, 1'b1);
    chk("first_pc", {25'b0, out_pc}, 32'h00);
    chk("first_instr", out_instr, 32'h00500093);
    chk("first_addr", {25'b0, imem_addr}, 32'h04);
    cycle(1'b0, 7'h00, 1'b1);
    chk("second_instr", out_instr, 32'h00A00113);
    repeat (3) cycle(1'b0, 7'h00, 1'b0);
    chk("stall_pc", {25'b0, out_pc}, 32'h04);
    chk("stall_instr", out_instr, 32'h00A00113);
    chk("stall_addr", {25'b0, imem_addr}, 32'h08);
    chk("stall_count", fetch_count, 32'd1);
    cycle(1'b0, 7'h00, 1'b1);
    chk("resume_pc", {25'b0, out_pc}, 32'h08);
    chk("resume_instr", out_instr, 32'h002081B3);

    // EBREAK delivery and halt, then redirect out of HALT.
    cycle(1'b0, 7'h00, 1'b1);
    chk("ebreak_pc", {25'b0, out_pc}, 32'h0C);
    chk("ebreak_halt", {31'b0, halted}, 32'd1);
    chk("ebreak_count", fetch_count, 32'd3);
    repeat (2) cycle(1'b0, 7'h00, 1'b1);
    chk("halt_novalid", {31'b0, out_valid}, 32'd0);
    chk("halt_count", fetch_count, 32'd4);
    cycle(1'b1, 7'h20, 1'b1);
    chk("redir_unhalt", {31'b0, halted}, 32'd0);
    chk("redir_addr", {25'b0, imem_addr}, 32'h20);
    cycle(1'b0, 7'h00, 1'b1);
    chk("redir_pc", {25'b0, out_pc}, 32'h20);

    // Wrap at the top of the address space; the 0x20 fire still counts.
    cycle(1'b1, 7'h7C, 1'b1);
    chk("wrap_count", fetch_count, 32'd5);
    cycle(1'b0, 7'h00, 1'b1);
    chk("wrap_pc0", {25'b0, out_pc}, 32'h7C);
    chk("wrap_addr", {25'b0, imem_addr}, 32'h00);
    cycle(1'b0, 7'h00, 1'b1);
    chk("wrap_pc1", {25'b0, out_pc}, 32'h00);

    // Misaligned redirect faults; later redirects ignored; async reset clears.
    cycle(1'b1, 7'h22, 1'b0);
    chk("fault_set", {31'b0, fault}, 32'd1);
    chk("fault_halted", {31'b0, halted}, 32'd1);
    chk("fault_novalid", {31'b0, out_valid}, 32'd0);
    cycle(1'b1, 7'h20, 1'b1);
    chk("fault_sticky", {31'b0, fault}, 32'd1);
    chk("fault_addr", {25'b0, imem_addr}, 32'h04);
    async_reset();

    // Redirect while an instruction is pending and not accepted drops it.
    cycle(1'b0, 7'h00, 1'b0);
    cycle(1'b1, 7'h40, 1'b0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    cycle(1'b0, 7'h00, 1'b1);
    chk("flush_pc", {25'b0, out_pc}, 32'h40);

    // Randomized traffic with sprinkled EBREAKs against the model.
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) == 0) w = EBREAK;
      else if (w == EBREAK) w = w ^ 32'd1;
      mem[i] = w;
    end
    fault_cycles = 0;
    for (int n = 0; n < 1500; n++) begin
      rpc = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 15) != 0) rpc[1:0] = 2'b00;
      cycle(($urandom_range(0, 7) == 0), rpc, ($urandom_range(0, 3) != 0));
      if (m_state == 2) fault_cycles++;
      if (fault_cycles > 4) begin
        async_reset();
        fault_cycles = 0;
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
